// File: rtl/chunked_add_sequencer.sv
// Chunked adder sequencer: performs a WIDTH-bit add by driving one external CHUNK-bit
// parallel adder once per clock, least-significant chunk first. The inter-chunk carry
// lives in carry_q, so the block itself never closes a path from add_cout to add_cin.
module chunked_add_sequencer #(
  parameter  int unsigned CHUNK  = 4,
  parameter  int unsigned NCHUNK = 4,
  localparam int unsigned WIDTH  = CHUNK * NCHUNK
) (
  input  logic             clock,
  input  logic             reset_n,
  // operand source
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  // result sink
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  // external narrow adder
  output logic [CHUNK-1:0] add_a,
  output logic [CHUNK-1:0] add_b,
  output logic             add_cin,
  input  logic [CHUNK-1:0] add_sum,
  input  logic             add_cout
);

  localparam int unsigned IdxW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;

  // Status outputs decode directly from the state register.
  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

  // Select the current chunk of the latched operands for the adder; quiet outside RUN.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == StRun) begin
      for (int unsigned i = 0; i < NCHUNK; i++) begin
        if (idx_q == IdxW'(i)) begin
          add_a = a_q[i*CHUNK +: CHUNK];
          add_b = b_q[i*CHUNK +: CHUNK];
        end
      end
      add_cin = carry_q;
    end
  end

  // Next-state: accept operands, step through chunks, then hold the result until taken.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int unsigned i = 0; i < NCHUNK; i++) begin
          if (idx_q == IdxW'(i)) begin
            sum_d[i*CHUNK +: CHUNK] = add_sum;
          end
        end
        carry_d = add_cout;
        if (idx_q == IdxLast) begin
          cout_d      = add_cout;
          idx_d       = '0;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  // State register; async reset aborts any operation in flight and clears the result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_chunked_add_sequencer.sv
// Bench for chunked_add_sequencer: a 4x4 instance checked every cycle against a
// transaction-level model, plus a 4x1 instance exercised back-to-back.
module tb_chunked_add_sequencer;

  localparam int C0 = 4;
  localparam int N0 = 4;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  // 4x4 instance
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [15:0] a, b, sum;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  // 4x1 instance
  logic        in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
  logic [3:0]  a1, b1, sum1;
  logic [3:0]  add_a1, add_b1, add_sum1;
  logic        add_cin1, add_cout1;

  // Reference parallel adders on the add_* ports.
  assign {add_cout, add_sum}   = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
  assign {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + {4'd0, add_cin1};

  chunked_add_sequencer #(.CHUNK(C0), .NCHUNK(N0)) u_dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy), .add_a(add_a), .add_b(add_b),
    .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
  );

  chunked_add_sequencer #(.CHUNK(4), .NCHUNK(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .busy(busy1), .add_a(add_a1), .add_b(add_b1),
    .add_cin(add_cin1), .add_sum(add_sum1), .add_cout(add_cout1)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Transaction model: one op outstanding, result a+b+cin visible N0 edges after accept.
  logic        m_pending;
  int          m_edge, m_acc;
  logic [15:0] m_a, m_b;
  logic        m_cin;
  logic [16:0] m_res;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_pending <= 1'b0;
      m_edge    <= 0;
    end else begin
      m_edge <= m_edge + 1;
      if (!m_pending) begin
        if (in_valid) begin
          m_pending <= 1'b1;
          m_a       <= a;
          m_b       <= b;
          m_cin     <= cin;
          m_res     <= {1'b0, a} + {1'b0, b} + {16'd0, cin};
          m_acc     <= m_edge + 1;
        end
      end else if ((m_edge + 1 > m_acc + N0) && out_ready) begin
        m_pending <= 1'b0;
      end
    end
  end

  // Per-cycle compare against the model; also logs add_cin during the chunk steps.
  logic mon_en = 1'b0;
  logic cin_log[$];

  always @(negedge clock) begin : p_cmp
    logic        ev, in_run;
    int          step;
    logic [31:0] mask, ea, eb, ec;
    if (reset_n && mon_en) begin
      ev     = m_pending && (m_edge >= m_acc + N0);
      in_run = m_pending && !ev;
      chk("in_ready", {31'd0, in_ready}, {31'd0, !m_pending});
      chk("busy", {31'd0, busy}, {31'd0, m_pending});
      chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
      if (ev) chk("result", {15'd0, cout, sum}, {15'd0, m_res});
      if (in_run) begin
        step = m_edge - m_acc;
        mask = (32'd1 << (step * C0)) - 32'd1;
        ea   = ({16'd0, m_a} >> (step * C0)) & 32'hF;
        eb   = ({16'd0, m_b} >> (step * C0)) & 32'hF;
        ec   = ((({16'd0, m_a} & mask) + ({16'd0, m_b} & mask) + {31'd0, m_cin})
               >> (step * C0)) & 32'd1;
        chk("add_a", {28'd0, add_a}, ea);
        chk("add_b", {28'd0, add_b}, eb);
        chk("add_cin", {31'd0, add_cin}, ec);
        cin_log.push_back(add_cin);
      end else begin
        chk("add_idle", {23'd0, add_a, add_b, add_cin}, 32'd0);
      end
    end
  end

  // Issue one op on the 4x4 instance; optionally stall the result for `stall` cycles.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                        input int stall, output logic [15:0] gs, output logic gc,
                        output int lat);
    int k;
    logic [15:0] s0;
    logic        c0;
    k = 0;
    @(negedge clock);
    while (!in_ready && k < 50) begin
      @(negedge clock);
      k++;
    end
    if (!in_ready) fail_now("in_ready_wait");
    cin_log.delete();
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    a = ta; b = tb; cin = tc;
    @(negedge clock);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    if (!out_valid) fail_now("out_valid_wait");
    gs = sum;
    gc = cout;
    if (stall > 0) begin
      s0 = sum;
      c0 = cout;
      for (int i = 0; i < stall; i++) begin
        in_valid = 1'b1;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        @(negedge clock);
        chk("stall_sum", {16'd0, sum}, {16'd0, s0});
        chk("stall_cout", {31'd0, cout}, {31'd0, c0});
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clock);
    end
  endtask

  // One op on the 4x1 instance: result one edge after accept.
  task automatic op1(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
    int k;
    logic [4:0] e;
    k = 0;
    while (!in_ready1 && k < 20) begin
      @(negedge clock);
      k++;
    end
    if (!in_ready1) fail_now("in_ready1_wait");
    in_valid1 = 1'b1;
    a1 = ta; b1 = tb; cin1 = tc;
    e = {1'b0, ta} + {1'b0, tb} + {4'd0, tc};
    @(negedge clock);
    in_valid1 = 1'b0;
    chk("n1_run_valid", {31'd0, out_valid1}, 32'd0);
    @(negedge clock);
    chk("n1_valid", {31'd0, out_valid1}, 32'd1);
    chk("n1_result", {27'd0, cout1, sum1}, {27'd0, e});
    @(negedge clock);
  endtask

  logic [15:0] gs;
  logic        gc;
  int          lat;

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", {15'd0, cout, sum}, 32'd0);
    chk("rst_add", {23'd0, add_a, add_b, add_cin}, 32'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // 1: no carries anywhere
    run_op(16'h1234, 16'h4321, 1'b0, 0, gs, gc, lat);
    chk("t1_sum", {16'd0, gs}, 32'h5555);
    chk("t1_cout", {31'd0, gc}, 32'd0);
    chk("t1_latency", lat, N0 + 1);
    chk("t1_run_cycles", cin_log.size(), N0);
    for (int i = 0; i < cin_log.size(); i++) chk("t1_add_cin", {31'd0, cin_log[i]}, 32'd0);

    // 2: carry ripples through every chunk
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, gs, gc, lat);
    chk("t2_sum", {16'd0, gs}, 32'h0000);
    chk("t2_cout", {31'd0, gc}, 32'd1);
    chk("t2_run_cycles", cin_log.size(), 4);
    if (cin_log.size() == 4)
      chk("t2_cin_seq", {28'd0, cin_log[0], cin_log[1], cin_log[2], cin_log[3]}, 32'b0111);

    // 3: carry-in
    run_op(16'hFFFF, 16'h0000, 1'b1, 0, gs, gc, lat);
    chk("t3a_result", {15'd0, gc, gs}, 32'h10000);
    run_op(16'h0000, 16'h0000, 1'b1, 0, gs, gc, lat);
    chk("t3b_result", {15'd0, gc, gs}, 32'h00001);

    // 4: backpressure for 6 cycles, then a fresh op
    run_op(16'hA5A5, 16'h5A5A, 1'b1, 6, gs, gc, lat);
    chk("t4_result", {15'd0, gc, gs}, 32'h10000);
    run_op(16'h0F0F, 16'h0101, 1'b0, 0, gs, gc, lat);
    chk("t4_next", {15'd0, gc, gs}, 32'h01010);

    // 5: async reset in the second chunk step aborts the op
    @(negedge clock);
    in_valid = 1'b1; a = 16'h00FF; b = 16'h0001; cin = 1'b0;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_result", {15'd0, cout, sum}, 32'd0);
    chk("t5_add", {23'd0, add_a, add_b, add_cin}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("t5_no_valid", {31'd0, out_valid}, 32'd0);
    end
    run_op(16'h0002, 16'h0003, 1'b0, 0, gs, gc, lat);
    chk("t5_next", {15'd0, gc, gs}, 32'h00005);

    // 6: single-chunk instance
    @(negedge clock);
    op1(4'hF, 4'h1, 1'b1);
    chk("t6_sum", {28'd0, sum1}, 32'h1);
    chk("t6_cout", {31'd0, cout1}, 32'd1);
    for (int i = 0; i < 10; i++) op1(4'($urandom), 4'($urandom), 1'($urandom));

    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
